// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the RAM DMA initiator: bus widths,
// write-enable polarity, FSM state encoding and transfer mode.
package ram_dma_pkg;

    typedef logic [31:0] mem_addr_t;
    typedef logic [31:0] mem_word_t;

    localparam logic      WRITE_ENABLE  = 1'b1;
    localparam logic      WRITE_DISABLE = 1'b0;
    localparam mem_word_t ZERO_WORD     = 32'h0000_0000;
    localparam logic [3:0] SEL_ALL      = 4'hF;
    localparam logic [3:0] SEL_NONE     = 4'h0;
    localparam mem_addr_t WORD_STRIDE   = 32'd4;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_READ  = 2'd1,
        DMA_WRITE = 2'd2,
        DMA_DONE  = 2'd3
    } dma_state_t;

    typedef enum logic {
        DMA_MODE_COPY = 1'b0,
        DMA_MODE_FILL = 1'b1
    } dma_mode_t;

    // Byte address rounded down to its containing word.
    function automatic mem_addr_t align_word(input mem_addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ram_dma.sv
// Word-granular DMA initiator for the data RAM port. Copies len_i words
// from src_i to dst_i, or fills dst_i with pattern_i, one bus access per
// granted cycle. Outputs are decoded from the current state so that address
// and data stay stable while the arbiter withholds the grant.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      pattern_i,
    output logic             req_o,
    input  logic             grant_i,
    output logic             we_o,
    output logic [31:0]      addr_o,
    output logic [31:0]      data_o,
    output logic [3:0]       sel_o,
    input  logic [31:0]      data_i,
    output logic             busy_o,
    output logic             done_o
);

    dma_state_t       state, state_n;
    dma_mode_t        mode;
    mem_addr_t        src, dst;
    mem_word_t        pattern, rd_buf;
    logic [LEN_W-1:0] remaining;

    logic access_done;
    assign access_done = req_o && grant_i;

    // State register plus transfer registers (addresses, word count, buffer).
    always_ff @(posedge clk) begin
        // NOTE: every register here, FSM state included, is cleared by the
        // synchronous reset and updated with <= so all flops sample together.
        if (rst) begin
            state     <= DMA_IDLE;
            mode      <= DMA_MODE_COPY;
            src       <= ZERO_WORD;
            dst       <= ZERO_WORD;
            pattern   <= ZERO_WORD;
            rd_buf    <= ZERO_WORD;
            remaining <= '0;
        end else begin
            state <= state_n;
            case (state)
                DMA_IDLE: begin
                    if (start_i) begin
                        src       <= align_word(src_i);
                        dst       <= align_word(dst_i);
                        remaining <= len_i;
                        mode      <= dma_mode_t'(mode_i);
                        pattern   <= pattern_i;
                    end
                end
                DMA_READ: begin
                    if (access_done) begin
                        rd_buf <= data_i;
                        src    <= src + WORD_STRIDE;
                    end
                end
                DMA_WRITE: begin
                    if (access_done) begin
                        dst       <= dst + WORD_STRIDE;
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and bus output decode.
    always_comb begin
        // NOTE: all outputs of this block get a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_n = state;
        req_o   = 1'b0;
        we_o    = WRITE_DISABLE;
        addr_o  = ZERO_WORD;
        data_o  = ZERO_WORD;
        sel_o   = SEL_NONE;
        busy_o  = 1'b0;
        done_o  = 1'b0;

        case (state)
            DMA_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_n = DMA_DONE;
                    end else if (mode_i == DMA_MODE_FILL) begin
                        state_n = DMA_WRITE;
                    end else begin
                        state_n = DMA_READ;
                    end
                end
            end
            DMA_READ: begin
                req_o  = 1'b1;
                busy_o = 1'b1;
                addr_o = src;
                if (grant_i) begin
                    state_n = DMA_WRITE;
                end
            end
            DMA_WRITE: begin
                req_o  = 1'b1;
                busy_o = 1'b1;
                addr_o = dst;
                data_o = (mode == DMA_MODE_FILL) ? pattern : rd_buf;
                // Write strobes follow the grant so the RAM is never written
                // in a cycle the arbiter has given to someone else.
                we_o   = grant_i ? WRITE_ENABLE : WRITE_DISABLE;
                sel_o  = grant_i ? SEL_ALL : SEL_NONE;
                if (grant_i) begin
                    if (remaining == LEN_W'(1)) begin
                        state_n = DMA_DONE;
                    end else if (mode == DMA_MODE_FILL) begin
                        state_n = DMA_WRITE;
                    end else begin
                        state_n = DMA_READ;
                    end
                end
            end
            DMA_DONE: begin
                done_o  = 1'b1;
                state_n = DMA_IDLE;
            end
            default: state_n = DMA_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_dma.sv
// Scoreboard bench for ram_dma: directed jobs push their expected writes and
// completion cycle into queues; a negedge monitor pops and compares them
// against what the DUT drives onto the RAM port.
module tb_ram_dma;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, mode_i, grant_i;
    logic [31:0] src_i, dst_i, pattern_i, data_i;
    logic [15:0] len_i;
    logic        req_o, we_o, busy_o, done_o;
    logic [31:0] addr_o, data_o;
    logic [3:0]  sel_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr_q[$];
    int          exp_done_q[$];
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    int          req_seen = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] held_addr, held_data;

    ram_dma #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .src_i(src_i), .dst_i(dst_i), .len_i(len_i), .pattern_i(pattern_i),
        .req_o(req_o), .grant_i(grant_i), .we_o(we_o), .addr_o(addr_o),
        .data_o(data_o), .sel_o(sel_o), .data_i(data_i), .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp done_o.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: combinational read, write on the clock edge.
    assign data_i = mem[addr_o[9:2]];
    always @(posedge clk) begin
        if (we_o) mem[addr_o[9:2]] = data_o;
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] addr);
        return mem[addr[9:2]];
    endfunction

    function automatic logic [71:0] out_vec();
        return {req_o, we_o, addr_o, data_o, sel_o, busy_o, done_o};
    endfunction

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_wr_q.push_back('{addr: addr, data: data});
    endtask

    // Monitor: compares every write, completion pulse and stalled cycle.
    always @(negedge clk) begin
        if (req_o) req_seen++;
        if (we_o) begin
            check("we_without_grant", 72'(grant_i), 72'(1));
            check("write_sel", 72'(sel_o), 72'(4'hF));
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", 72'(addr_o), 72'hBAD);
            end else begin
                wr_t w;
                w = exp_wr_q.pop_front();
                check("write_addr", 72'(addr_o), 72'(w.addr));
                check("write_data", 72'(data_o), 72'(w.data));
            end
        end else if (sel_o != 4'h0) begin
            check("sel_without_write", 72'(sel_o), 72'(0));
        end
        if (done_o) begin
            done_seen++;
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 72'(cyc), 72'hBAD);
            end else begin
                check("done_cycle", 72'(cyc), 72'(exp_done_q.pop_front()));
            end
        end
        if (prev_stall && req_o) begin
            check("stall_addr_stable", 72'(addr_o), 72'(held_addr));
            check("stall_data_stable", 72'(data_o), 72'(held_data));
        end
        prev_stall = req_o && !grant_i;
        held_addr  = addr_o;
        held_data  = data_o;
    end

    // Issue one job; exp_done is the cycle (edge 0 = start sample) in which
    // done_o must be high, 0 when no completion is expected.
    task automatic run_job(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic [31:0] p, input bit stall,
                           input int rst_cyc, input int busy_cyc, input int exp_done);
        int  base_done;
        bit  finished;
        finished  = 1'b0;
        base_done = done_seen;
        mode_i = m; src_i = s; dst_i = d; len_i = n; pattern_i = p;
        grant_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (exp_done > 0) exp_done_q.push_back(cyc + exp_done - 1);
        for (int c = 1; c <= TIMEOUT; c++) begin
            grant_i = stall ? (c % 2 == 0) : 1'b1;
            rst     = (c == rst_cyc);
            if (c == busy_cyc) begin
                start_i = 1'b1; mode_i = 1'b1; dst_i = 32'h300;
                len_i = 16'd5; pattern_i = 32'h0;
            end
            @(posedge clk); #1;
            rst     = 1'b0;
            start_i = 1'b0;
            if (rst_cyc > 0 && c == rst_cyc) begin
                check("outputs_after_rst", out_vec(), 72'h0);
                finished = 1'b1;
                break;
            end
            if (done_seen != base_done) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("job_timeout", 72'(0), 72'(1));
        grant_i = 1'b1;
    endtask

    initial begin
        int base_req;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h11; mem[8'h41] = 32'h22; mem[8'h42] = 32'h33; mem[8'h43] = 32'h44;
        mem[8'h44] = 32'h55; mem[8'h45] = 32'h66; mem[8'h46] = 32'h77; mem[8'h47] = 32'h88;
        mem[8'h13] = 32'h5A5A_5A5A;
        rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; grant_i = 1'b1;
        src_i = 32'h0; dst_i = 32'h0; len_i = 16'h0; pattern_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", out_vec(), 72'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Copy 4 words with continuous grant.
        push_wr(32'h200, 32'h11); push_wr(32'h204, 32'h22);
        push_wr(32'h208, 32'h33); push_wr(32'h20C, 32'h44);
        run_job(1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 1'b0, 0, 0, 9);
        check("copy_mem_200", 72'(mrd(32'h200)), 72'(32'h11));
        check("copy_mem_20c", 72'(mrd(32'h20C)), 72'(32'h44));

        // Fill 3 words.
        push_wr(32'h40, 32'hDEADBEEF); push_wr(32'h44, 32'hDEADBEEF);
        push_wr(32'h48, 32'hDEADBEEF);
        run_job(1'b1, 32'h0, 32'h40, 16'd3, 32'hDEADBEEF, 1'b0, 0, 0, 4);
        check("fill_mem_48", 72'(mrd(32'h48)), 72'(32'hDEADBEEF));
        check("fill_mem_4c_untouched", 72'(mrd(32'h4C)), 72'(32'h5A5A_5A5A));

        // Copy 2 words with grant low in cycles 1,3,5,7: 5 + 4 stall cycles.
        push_wr(32'h280, 32'h33); push_wr(32'h284, 32'h44);
        run_job(1'b0, 32'h108, 32'h280, 16'd2, 32'h0, 1'b1, 0, 0, 9);
        check("stall_mem_284", 72'(mrd(32'h284)), 72'(32'h44));

        // Zero-length job: done in cycle 1, bus never requested.
        base_req = req_seen;
        run_job(1'b0, 32'h100, 32'h200, 16'd0, 32'h0, 1'b0, 0, 0, 1);
        check("len0_no_req", 72'(req_seen), 72'(base_req));

        // Unaligned addresses are rounded down to the word.
        push_wr(32'h204, 32'h11);
        run_job(1'b0, 32'h103, 32'h206, 16'd1, 32'h0, 1'b0, 0, 0, 3);
        check("unaligned_mem_204", 72'(mrd(32'h204)), 72'(32'h11));

        // Destination wraps from the top of the address space to zero.
        push_wr(32'hFFFF_FFFC, 32'hCAFE_F00D); push_wr(32'h0000_0000, 32'hCAFE_F00D);
        run_job(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'hCAFE_F00D, 1'b0, 0, 0, 3);

        // Reset during the 2nd write of an 8-word copy: that write commits.
        push_wr(32'h300, 32'h11); push_wr(32'h304, 32'h22);
        run_job(1'b0, 32'h100, 32'h300, 16'd8, 32'h0, 1'b0, 4, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("rst_mem_304_committed", 72'(mrd(32'h304)), 72'(32'h22));
        check("rst_mem_308_unwritten", 72'(mrd(32'h308)), 72'(32'h0));

        // start_i pulsed mid-transfer with other parameters is ignored.
        push_wr(32'h380, 32'h11); push_wr(32'h384, 32'h22);
        run_job(1'b0, 32'h100, 32'h380, 16'd2, 32'h0, 1'b0, 0, 2, 5);
        repeat (8) @(posedge clk);
        #1;
        check("busy_start_ignored_300", 72'(mrd(32'h300)), 72'(32'h11));
        check("busy_start_no_done", 72'(done_o), 72'(0));

        check("writes_outstanding", 72'(exp_wr_q.size()), 72'(0));
        check("dones_outstanding", 72'(exp_done_q.size()), 72'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
